// File: rtl/gate_mode_demonstration.sv
// -----------------------------------------------------------------------------
// gate_mode_demonstration
//
// Purpose:
//   Board demo for a configurable multi-input logic gate. A bank of slide
//   switches supplies the operands. A push-button steps the gate function
//   through AND -> OR -> XOR -> NAND -> NOR -> XNOR and then back to AND.
//   LEDs show the conditioned operands, the gate result and the mode index.
//
//   Every asynchronous pin goes through a 2-flop synchroniser. When the
//   debouncers are compiled in, each synchronised pin also needs
//   DEBOUNCE_CYCLES consecutive cycles at a new level before that level is
//   accepted as the "stable" value. All downstream logic uses stable values
//   only.
//
// Configuration macro:
//   GATE_DEMO_DEBOUNCE_EN
//     defined   : debouncers present on every switch and on the button.
//                 Pin-to-LED latency is DEBOUNCE_CYCLES+3 clocks.
//     undefined : stable value = synchroniser output. DEBOUNCE_CYCLES has
//                 no effect. Pin-to-LED latency is 3 clocks.
//
// Parameters:
//   NUM_INPUTS      : gate operand count (2..8)
//   DEBOUNCE_CYCLES : stable cycles needed to accept a new level (>= 2)
//
// Ports:
//   I_P_CLK       in   1           single clock for all logic
//   I_P_RST_N     in   1           synchronous, active-low reset
//   I_P_SW        in   NUM_INPUTS  asynchronous switch operands
//   I_P_BTN_MODE  in   1           asynchronous mode-advance button
//   O_P_LED_IN    out  NUM_INPUTS  registered echo of stable operands
//   O_P_LED_GATE  out  1           registered gate result
//   O_P_LED_MODE  out  3           mode register (also the FSM state)
//
// Handshake: none. The pins are level inputs and the LEDs are level outputs.
// -----------------------------------------------------------------------------
module gate_mode_demonstration #(
  parameter int NUM_INPUTS      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  I_P_CLK,
  input  logic                  I_P_RST_N,
  input  logic [NUM_INPUTS-1:0] I_P_SW,
  input  logic                  I_P_BTN_MODE,
  output logic [NUM_INPUTS-1:0] O_P_LED_IN,
  output logic                  O_P_LED_GATE,
  output logic [2:0]            O_P_LED_MODE
);

  // Switches and button are conditioned as one vector.
  // The button sits in the top bit.
  localparam int NSIG    = NUM_INPUTS + 1;
  localparam int BTN_IDX = NUM_INPUTS;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  // ---------------------------------------------------------------------------
  // 2-flop synchronisers
  // ---------------------------------------------------------------------------
  logic [NSIG-1:0] raw;
  logic [NSIG-1:0] sync1_q;
  logic [NSIG-1:0] sync2_q;
  logic [NSIG-1:0] stable;

  assign raw = {I_P_BTN_MODE, I_P_SW};

  always_ff @(posedge I_P_CLK) begin
    if (!I_P_RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef GATE_DEMO_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debouncers: one stable bit and one counter per conditioned signal.
  // The counter counts cycles in which synced differs from stable.
  // Any cycle that agrees with stable restarts the count.
  // On the DEBOUNCE_CYCLES-th consecutive differing cycle, stable takes the
  // synced value and the counter clears.
  // ---------------------------------------------------------------------------
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NSIG-1:0] stable_q;
  logic [NSIG-1:0] stable_d;
  logic [CW-1:0]   cnt_q [NSIG];
  logic [CW-1:0]   cnt_d [NSIG];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NSIG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge I_P_CLK) begin
    if (!I_P_RST_N) begin
      stable_q <= '0;
      for (int i = 0; i < NSIG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NSIG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable = stable_q;
`else
  // No debouncers in this build: the synchroniser output is the stable value.
  // DEBOUNCE_CYCLES has no effect here and is only referenced to keep the
  // parameter in use.
  logic deb_cfg_unused;
  assign deb_cfg_unused = (DEBOUNCE_CYCLES >= 2);
  assign stable         = sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Button edge detection with post-reset arming
  //
  // After reset, the stable button value is 0 even if the button is held.
  // A held button would therefore look like a fresh 0->1 edge once its level
  // works through the synchroniser and debouncer. To block that, edges only
  // count after the button has been seen released.
  //
  // warm_q waits until the synchroniser holds real pin data. From then on,
  // a synced 0 on the button sets arm_q.
  // ---------------------------------------------------------------------------
  logic       btn_prev_q;
  logic       arm_q;
  logic       arm_d;
  logic [1:0] warm_q;
  logic [1:0] warm_d;
  logic       sync_valid;
  logic       btn_rise;

  assign sync_valid = (warm_q == 2'd2);
  assign warm_d     = sync_valid ? warm_q : (warm_q + 2'd1);
  assign arm_d      = arm_q | (sync_valid & ~sync2_q[BTN_IDX]);
  assign btn_rise   = stable[BTN_IDX] & ~btn_prev_q & arm_q;

  always_ff @(posedge I_P_CLK) begin
    if (!I_P_RST_N) begin
      btn_prev_q <= 1'b0;
      arm_q      <= 1'b0;
      warm_q     <= 2'd0;
    end else begin
      btn_prev_q <= stable[BTN_IDX];
      arm_q      <= arm_d;
      warm_q     <= warm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM
  // The mode register is the state and is driven straight out on
  // O_P_LED_MODE. Codes 6 and 7 are unreachable. If either appears, the FSM
  // recovers to AND on the next cycle.
  // ---------------------------------------------------------------------------
  logic [2:0] mode_q;
  logic [2:0] mode_d;

  always_comb begin
    mode_d = mode_q;
    if (mode_q > MODE_XNOR) begin
      mode_d = MODE_AND;
    end else if (btn_rise) begin
      mode_d = (mode_q == MODE_XNOR) ? MODE_AND : (mode_q + 3'd1);
    end
  end

  always_ff @(posedge I_P_CLK) begin
    if (!I_P_RST_N) begin
      mode_q <= MODE_AND;
    end else begin
      mode_q <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate evaluation and LED registers
  // The operands and the mode are sampled by the same register stage.
  // A mode change and an operand change arriving in the same cycle therefore
  // reach the LED together, with no mixed intermediate value.
  // ---------------------------------------------------------------------------
  logic [NUM_INPUTS-1:0] operands;
  logic                  gate_d;
  logic [NUM_INPUTS-1:0] led_in_q;
  logic                  led_gate_q;

  assign operands = stable[NUM_INPUTS-1:0];

  always_comb begin
    gate_d = 1'b0;
    case (mode_q)
      MODE_AND:  gate_d = &operands;
      MODE_OR:   gate_d = |operands;
      MODE_XOR:  gate_d = ^operands;
      MODE_NAND: gate_d = ~&operands;
      MODE_NOR:  gate_d = ~|operands;
      MODE_XNOR: gate_d = ~^operands;
      default:   gate_d = 1'b0;  // unreachable codes force the LED off
    endcase
  end

  always_ff @(posedge I_P_CLK) begin
    if (!I_P_RST_N) begin
      led_in_q   <= '0;
      led_gate_q <= 1'b0;
    end else begin
      led_in_q   <= operands;
      led_gate_q <= gate_d;
    end
  end

  assign O_P_LED_IN   = led_in_q;
  assign O_P_LED_GATE = led_gate_q;
  assign O_P_LED_MODE = mode_q;

endmodule

// File: tb/tb_gate_mode_demonstration.sv
// -----------------------------------------------------------------------------
// tb_gate_mode_demonstration
//
// Directed bench for gate_mode_demonstration with NUM_INPUTS=4 and
// DEBOUNCE_CYCLES=4.
//
// LAT is the pin-to-LED latency in clocks:
//   DEBOUNCE_CYCLES+3 when GATE_DEMO_DEBOUNCE_EN is defined, 3 otherwise.
//
// A button pressed just after edge P updates the mode register at edge
// P+LAT and the gate LED at edge P+LAT+1.
//
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, after the registers have settled.
// -----------------------------------------------------------------------------
module tb_gate_mode_demonstration;

  localparam int N = 4;
  localparam int D = 4;
`ifdef GATE_DEMO_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 3;
`endif

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw;
  logic         btn;
  logic [N-1:0] led_in;
  logic         led_gate;
  logic [2:0]   led_mode;

  int checks;
  int errors;
  int exp_mode;  // bench-side record of the mode the DUT should be in

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_mode_demonstration #(
    .NUM_INPUTS      (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .I_P_CLK      (clk),
    .I_P_RST_N    (rst_n),
    .I_P_SW       (sw),
    .I_P_BTN_MODE (btn),
    .O_P_LED_IN   (led_in),
    .O_P_LED_GATE (led_gate),
    .O_P_LED_MODE (led_mode)
  );

  // Watchdog: abort the run if it stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold, input int gap);
    btn = 1'b1;
    tick(hold);
    btn = 1'b0;
    tick(gap);
    exp_mode = (exp_mode + 1) % 6;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------

  // Reset clears all three LED outputs, both while reset is held and on the
  // first cycle after release.
  task automatic test_reset();
    rst_n = 1'b0;
    sw    = '0;
    btn   = 1'b0;
    tick(2);
    checks++;
    if (led_in !== 4'b0000) begin
      errors++; $display("FAIL reset_led_in: got %b expected 0000", led_in);
    end
    checks++;
    if (led_gate !== 1'b0) begin
      errors++; $display("FAIL reset_led_gate: got %b expected 0", led_gate);
    end
    checks++;
    if (led_mode !== 3'd0) begin
      errors++; $display("FAIL reset_led_mode: got %0d expected 0", led_mode);
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (led_in !== 4'b0000 || led_gate !== 1'b0 || led_mode !== 3'd0) begin
      errors++;
      $display("FAIL post_reset: got in=%b gate=%b mode=%0d expected 0000/0/0",
               led_in, led_gate, led_mode);
    end
    exp_mode = 0;
  endtask

  // SW=1111 held: LED_IN and LED_GATE change exactly LAT clocks later.
  task automatic test_latency();
    sw = 4'b1111;
    tick(LAT - 1);
    checks++;
    if (led_in !== 4'b0000 || led_gate !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got in=%b gate=%b expected 0000/0",
               led_in, led_gate);
    end
    tick(1);
    checks++;
    if (led_in !== 4'b1111) begin
      errors++; $display("FAIL latency_led_in: got %b expected 1111", led_in);
    end
    checks++;
    if (led_gate !== 1'b1) begin
      errors++; $display("FAIL latency_gate: got %b expected 1", led_gate);
    end
    checks++;
    if (led_mode !== 3'd0) begin
      errors++; $display("FAIL latency_mode: got %0d expected 0", led_mode);
    end
  endtask

  // SW=1010 and six presses step through every mode. For each press, check:
  //   - the mode is unchanged one cycle before its update edge,
  //   - the mode steps on the update edge,
  //   - the gate result follows one cycle after the mode.
  task automatic test_mode_cycle();
    logic [2:0] exp_m [6];
    logic       exp_g [6];
    logic [2:0] old_m;
    exp_m = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sw = 4'b1010;
    tick(LAT + 2);
    old_m = 3'd0;
    for (int i = 0; i < 6; i++) begin
      btn = 1'b1;
      tick(LAT - 1);
      checks++;
      if (led_mode !== old_m) begin
        errors++;
        $display("FAIL mode_hold%0d: got %0d expected %0d", i, led_mode, old_m);
      end
      tick(1);
      checks++;
      if (led_mode !== exp_m[i]) begin
        errors++;
        $display("FAIL mode_step%0d: got %0d expected %0d", i, led_mode, exp_m[i]);
      end
      tick(1);
      checks++;
      if (led_gate !== exp_g[i]) begin
        errors++;
        $display("FAIL gate_step%0d: got %b expected %b", i, led_gate, exp_g[i]);
      end
      tick(10 - (LAT + 1));
      btn = 1'b0;
      tick(10);
      old_m = exp_m[i];
    end
    exp_mode = 0;
  endtask

  // A mode change and an operand change land in the same cycle:
  // AND with SW=1010 (gate 0) becomes OR with SW=1110 (gate 1).
  // The gate LED holds its old value, then shows both changes together.
  task automatic test_simultaneous();
    btn = 1'b1;
    tick(1);
    sw = 4'b1110;
    tick(LAT - 1);
    checks++;
    if (led_gate !== 1'b0 || led_in !== 4'b1010) begin
      errors++;
      $display("FAIL simul_before: got gate=%b in=%b expected 0/1010",
               led_gate, led_in);
    end
    tick(1);
    checks++;
    if (led_gate !== 1'b1 || led_in !== 4'b1110 || led_mode !== 3'd1) begin
      errors++;
      $display("FAIL simul_after: got gate=%b in=%b mode=%0d expected 1/1110/1",
               led_gate, led_in, led_mode);
    end
    btn = 1'b0;
    tick(10);
    exp_mode = 1;
  endtask

`ifdef GATE_DEMO_DEBOUNCE_EN
  // A 3-clock pulse on SW[0], shorter than DEBOUNCE_CYCLES, never reaches
  // the LEDs. Mode is OR with operands 0000, so the gate stays 0.
  task automatic test_glitch();
    sw = 4'b0000;
    tick(LAT + 2);
    checks++;
    if (led_in !== 4'b0000 || led_gate !== 1'b0) begin
      errors++;
      $display("FAIL glitch_base: got in=%b gate=%b expected 0000/0",
               led_in, led_gate);
    end
    sw = 4'b0001;
    tick(3);
    sw = 4'b0000;
    for (int i = 0; i < LAT + 5; i++) begin
      tick(1);
      checks++;
      if (led_in !== 4'b0000 || led_gate !== 1'b0) begin
        errors++;
        $display("FAIL glitch_cycle%0d: got in=%b gate=%b expected 0000/0",
                 i, led_in, led_gate);
      end
    end
  endtask
`else
  // With the debouncers removed, in XOR mode, SW 0000->0001 lights the gate
  // LED exactly 3 clocks later.
  task automatic test_xor_fast();
    press(10, 10);  // OR -> XOR
    checks++;
    if (led_mode !== 3'd2) begin
      errors++; $display("FAIL xor_mode: got %0d expected 2", led_mode);
    end
    sw = 4'b0000;
    tick(LAT + 2);
    sw = 4'b0001;
    tick(2);
    checks++;
    if (led_gate !== 1'b0) begin
      errors++; $display("FAIL xor_early: got %b expected 0", led_gate);
    end
    tick(1);
    checks++;
    if (led_gate !== 1'b1 || led_in !== 4'b0001) begin
      errors++;
      $display("FAIL xor_gate: got gate=%b in=%b expected 1/0001",
               led_gate, led_in);
    end
  endtask
`endif

  // A button held for 50 clocks advances the mode exactly once.
  // Releasing it does not advance the mode again.
  task automatic test_held_button();
    int want;
    want = (exp_mode + 1) % 6;
    btn = 1'b1;
    tick(50);
    checks++;
    if (led_mode !== 3'(want)) begin
      errors++; $display("FAIL held_mode: got %0d expected %0d", led_mode, want);
    end
    btn = 1'b0;
    tick(20);
    checks++;
    if (led_mode !== 3'(want)) begin
      errors++;
      $display("FAIL release_mode: got %0d expected %0d", led_mode, want);
    end
    exp_mode = want;
  endtask

  // Steps:
  //   1. Reach mode 3.
  //   2. Start a switch debounce with the button held.
  //   3. Assert reset for one edge and check that everything clears.
  //   4. Keep the button held across reset release: no advance.
  //   5. Release and press again: mode advances to 1.
  task automatic test_reset_mid_op();
    while (exp_mode != 3) begin
      press(10, 10);
    end
    checks++;
    if (led_mode !== 3'd3) begin
      errors++; $display("FAIL pre_reset_mode: got %0d expected 3", led_mode);
    end
    sw  = 4'b1111;
    btn = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if (led_in !== 4'b0000 || led_gate !== 1'b0 || led_mode !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got in=%b gate=%b mode=%0d expected 0000/0/0",
               led_in, led_gate, led_mode);
    end
    rst_n = 1'b1;
    exp_mode = 0;
    tick(40);
    checks++;
    if (led_mode !== 3'd0) begin
      errors++; $display("FAIL held_through_reset: got %0d expected 0", led_mode);
    end
    checks++;
    if (led_in !== 4'b1111 || led_gate !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_ops: got in=%b gate=%b expected 1111/1",
               led_in, led_gate);
    end
    btn = 1'b0;
    tick(10);
    press(10, 10);
    checks++;
    if (led_mode !== 3'd1) begin
      errors++; $display("FAIL repress_mode: got %0d expected 1", led_mode);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks   = 0;
    errors   = 0;
    exp_mode = 0;
    test_reset();
    test_latency();
    test_mode_cycle();
    test_simultaneous();
`ifdef GATE_DEMO_DEBOUNCE_EN
    test_glitch();
`else
    test_xor_fast();
`endif
    test_held_button();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_mode_demonstration.md
GATE_MODE_DEMONSTRATION -- requirements
Module: gate_mode_demonstration

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: gate input count, legal range 2..8.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable cycles needed to accept a new input level (10 ms at 100 MHz), legal minimum 2.
REQ-003 SHALL have port I_P_CLK, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port I_P_RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port I_P_SW, input, NUM_INPUTS bits: asynchronous slide-switch gate operands.
REQ-006 SHALL have port I_P_BTN_MODE, input, 1 bit: asynchronous push-button that advances the gate mode.
REQ-007 SHALL have port O_P_LED_IN, output, NUM_INPUTS bits: registered echo of the conditioned operands.
REQ-008 SHALL have port O_P_LED_GATE, output, 1 bit: registered gate result.
REQ-009 SHALL have port O_P_LED_MODE, output, 3 bits: current mode index.

Function
REQ-010 SHALL pass each I_P_SW bit and I_P_BTN_MODE through a 2-flop synchroniser before any other use.
REQ-011 SHALL, per conditioned signal, keep a stable value and a counter: counter clears whenever synced equals stable; otherwise it increments, and after DEBOUNCE_CYCLES consecutive differing cycles stable takes synced and the counter clears.
REQ-012 SHALL not let a glitch shorter than DEBOUNCE_CYCLES cycles change a stable value.
REQ-013 SHALL run a 6-state mode FSM: AND(0) -> OR(1) -> XOR(2) -> NAND(3) -> NOR(4) -> XNOR(5) -> AND(0), with wrap from 5 to 0.
REQ-014 SHALL advance the mode exactly once per 0->1 edge of the stable button value, with the mode register updating one cycle after the edge.
REQ-015 SHALL not advance the mode on a held button or on release.
REQ-016 SHALL reduce all NUM_INPUTS stable operands with the current mode: AND/OR/XOR are reduction ops; NAND/NOR/XNOR are their complements.
REQ-017 SHALL treat mode codes 6 and 7 as unreachable; if either is ever present, the next cycle SHALL load AND(0) and O_P_LED_GATE SHALL drive 0.
REQ-018 SHALL register O_P_LED_IN and O_P_LED_GATE one cycle after the stable operands or mode they depend on.
REQ-019 SHALL drive O_P_LED_MODE directly from the mode register.
REQ-020 SHALL, when a mode change and an operand change land in the same cycle, show both in O_P_LED_GATE on the same following cycle, with no intermediate mixed value.
REQ-021 SHALL have a pin-to-LED latency of DEBOUNCE_CYCLES+3 clocks with debounce compiled in, and 3 clocks without.

Reset
REQ-022 SHALL, while I_P_RST_N=0 at a clock edge, clear all synchronisers, stable values and counters to 0, and set the mode to AND(0).
REQ-023 SHALL drive O_P_LED_IN=0, O_P_LED_GATE=0 and O_P_LED_MODE=0 out of reset.
REQ-024 SHALL abort any debounce count in progress on reset mid-operation; a button held through reset release SHALL NOT advance the mode until it is released and pressed again.

Configuration
REQ-025 SHALL use macro GATE_DEMO_DEBOUNCE_EN: when defined, the REQ-011 debouncers are compiled in for switches and button.
REQ-026 SHALL, when GATE_DEMO_DEBOUNCE_EN is undefined, remove the debouncers and take the stable value as the synchroniser output; DEBOUNCE_CYCLES is then ignored, and edge detection and the FSM are unchanged.

Verification (NUM_INPUTS=4, DEBOUNCE_CYCLES=4, debounce compiled in unless stated)
REQ-027 SHALL cover: reset, then SW=4'b1111 held -> LED_IN=1111 and LED_GATE=1 exactly 7 clocks later, with LED_MODE=0.
REQ-028 SHALL cover: SW=1010 stable, 6 button presses each held 10 clocks -> LED_MODE steps 1,2,3,4,5,0 and LED_GATE steps 1,0,1,0,1,0.
REQ-029 SHALL cover: a 3-clock pulse on SW[0] from 0000 -> LED_IN stays 0000 and LED_GATE unchanged.
REQ-030 SHALL cover: button held 50 clocks -> exactly one mode increment.
REQ-031 SHALL cover: reset asserted mid-debounce with mode=3 -> next cycle all outputs 0, mode 0; a button held across reset release gives no increment.
REQ-032 SHALL cover: debounce compiled out, SW 0000->0001 in XOR mode -> LED_GATE=1 exactly 3 clocks later.
